row_event_sequencer: RTL and testbench

ROW_EVENT_SEQUENCER -- requirements
Module: row_event_sequencer

---
 rtl/rowseq_pkg.sv | 14 +
 rtl/sync_edge_det.sv | 54 +++++
 rtl/row_event_sequencer.sv | 116 +++++++++++
 tb/tb_row_event_sequencer.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/rowseq_pkg.sv
// Shared types and default sizing for the row event sequencer.
// Build option ROWSEQ_SYNC_EN (see sync_edge_det) does not affect this package.
package rowseq_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    COUNT = 2'd1,
    HOLD  = 2'd2
  } rowseq_state_e;

  localparam int DEF_CNT_W = 9;
  localparam int DEF_NCH   = 2;

endpackage

// File: rtl/sync_edge_det.sv
// Optional 2-flop synchroniser plus falling-edge strobe for an active-low sync input.
// Define ROWSEQ_SYNC_EN to insert the synchroniser; otherwise the input is taken as cp-synchronous.
module sync_edge_det (
  input  logic cp,
  input  logic mr_n,
  input  logic d_n,
  output logic fall
);

  logic sig;
  logic sig_valid;
  logic prev_q;
  logic armed_q;

`ifdef ROWSEQ_SYNC_EN
  logic s1_q, s2_q;
  logic v1_q, v2_q;

  // v1/v2 mark when s2 holds a real sample rather than its reset value
  always_ff @(posedge cp or negedge mr_n) begin
    if (!mr_n) begin
      s1_q <= 1'b1;
      s2_q <= 1'b1;
      v1_q <= 1'b0;
      v2_q <= 1'b0;
    end else begin
      s1_q <= d_n;
      s2_q <= s1_q;
      v1_q <= 1'b1;
      v2_q <= v1_q;
    end
  end

  assign sig       = s2_q;
  assign sig_valid = v2_q;
`else
  assign sig       = d_n;
  assign sig_valid = 1'b1;
`endif

  // Arming only after a genuine high sample stops a held-low input at reset release from strobing
  always_ff @(posedge cp or negedge mr_n) begin
    if (!mr_n) begin
      prev_q  <= 1'b1;
      armed_q <= 1'b0;
    end else begin
      prev_q  <= sig;
      armed_q <= armed_q | (sig_valid & sig);
    end
  end

  assign fall = armed_q & prev_q & ~sig;

endmodule

// File: rtl/row_event_sequencer.sv
// Row counter driven by hs/fs sync edges with per-channel one-shot row-match pulses.
// Define ROWSEQ_SYNC_EN to synchronise hs_n/fs_n (3-edge latency instead of 1).
//
//   state | meaning
//   IDLE  | waiting for the first field sync after reset
//   COUNT | counting hs falls, compare channels armed
//   HOLD  | row saturated, waiting for next field sync
module row_event_sequencer
  import rowseq_pkg::*;
#(
  parameter int CNT_W = DEF_CNT_W,
  parameter int NCH   = DEF_NCH
) (
  input  logic                 cp,
  input  logic                 mr_n,
  input  logic                 hs_n,
  input  logic                 fs_n,
  input  logic [NCH*CNT_W-1:0] cmp,
  output logic [NCH-1:0]       q,
  output logic [CNT_W-1:0]     row,
  output logic                 active,
  output logic                 ovf
);

  logic hs_fall;
  logic fs_fall;

  rowseq_state_e        state_q, state_d;
  logic [CNT_W-1:0]     row_q, row_d;
  logic                 ovf_q, ovf_d;
  logic [NCH*CNT_W-1:0] cmp_l_q, cmp_l_d;
  logic [NCH-1:0]       fired_q, fired_d;
  logic [NCH-1:0]       q_q, q_d;
  logic                 row_upd;
  logic                 new_field;

  sync_edge_det u_hs (
    .cp   (cp),
    .mr_n (mr_n),
    .d_n  (hs_n),
    .fall (hs_fall)
  );

  sync_edge_det u_fs (
    .cp   (cp),
    .mr_n (mr_n),
    .d_n  (fs_n),
    .fall (fs_fall)
  );

  // fs_fall wins over a coincident hs_fall, so hs is only looked at in the else branch
  always_comb begin
    state_d   = state_q;
    row_d     = row_q;
    ovf_d     = ovf_q;
    cmp_l_d   = cmp_l_q;
    row_upd   = 1'b0;
    new_field = 1'b0;
    if (fs_fall) begin
      state_d   = COUNT;
      row_d     = '0;
      ovf_d     = 1'b0;
      cmp_l_d   = cmp;
      row_upd   = 1'b1;
      new_field = 1'b1;
    end else begin
      case (state_q)
        IDLE: ;
        COUNT: begin
          if (hs_fall) begin
            if (&row_q) begin
              ovf_d   = 1'b1;
              state_d = HOLD;
            end else begin
              row_d   = row_q + CNT_W'(1);
              row_upd = 1'b1;
            end
          end
        end
        HOLD: ;
        default: state_d = IDLE;
      endcase
    end
  end

  for (genvar i = 0; i < NCH; i++) begin : g_ch
    logic hit;
    assign hit        = row_upd & (row_d == cmp_l_d[i*CNT_W +: CNT_W]) & (new_field | ~fired_q[i]);
    assign q_d[i]     = hit;
    assign fired_d[i] = new_field ? hit : (fired_q[i] | hit);
  end

  always_ff @(posedge cp or negedge mr_n) begin
    if (!mr_n) begin
      state_q <= IDLE;
      row_q   <= '0;
      ovf_q   <= 1'b0;
      cmp_l_q <= '0;
      fired_q <= '0;
      q_q     <= '0;
    end else begin
      state_q <= state_d;
      row_q   <= row_d;
      ovf_q   <= ovf_d;
      cmp_l_q <= cmp_l_d;
      fired_q <= fired_d;
      q_q     <= q_d;
    end
  end

  assign q      = q_q;
  assign row    = row_q;
  assign active = (state_q == COUNT);
  assign ovf    = ovf_q;

endmodule

// File: tb/tb_row_event_sequencer.sv
// Directed bench for row_event_sequencer; latency expectations follow ROWSEQ_SYNC_EN.
module tb_row_event_sequencer;

`ifdef ROWSEQ_SYNC_EN
  localparam int LAT = 3;
`else
  localparam int LAT = 1;
`endif

  logic        cp   = 1'b0;
  logic        mr_n = 1'b0;
  logic        hs_n = 1'b1;
  logic        fs_n = 1'b1;
  logic [17:0] cmp  = '0;
  logic [1:0]  q;
  logic [8:0]  row;
  logic        active;
  logic        ovf;

  logic [4:0]  cmp5 = '0;
  logic [0:0]  q5;
  logic [4:0]  row5;
  logic        active5;
  logic        ovf5;

  int errs   = 0;
  int checks = 0;
  int qcnt0  = 0;
  int qcnt1  = 0;
  int qrow0  = 0;
  int qrow1  = 0;
  int q5cnt  = 0;
  int c0;

  always #5 cp = ~cp;

  row_event_sequencer #(.CNT_W(9), .NCH(2)) dut (
    .cp     (cp),
    .mr_n   (mr_n),
    .hs_n   (hs_n),
    .fs_n   (fs_n),
    .cmp    (cmp),
    .q      (q),
    .row    (row),
    .active (active),
    .ovf    (ovf)
  );

  row_event_sequencer #(.CNT_W(5), .NCH(1)) dut5 (
    .cp     (cp),
    .mr_n   (mr_n),
    .hs_n   (hs_n),
    .fs_n   (fs_n),
    .cmp    (cmp5),
    .q      (q5),
    .row    (row5),
    .active (active5),
    .ovf    (ovf5)
  );

  always @(negedge cp) begin
    if (q[0]) begin
      qcnt0 = qcnt0 + 1;
      qrow0 = int'(row);
    end
    if (q[1]) begin
      qcnt1 = qcnt1 + 1;
      qrow1 = int'(row);
    end
    if (q5[0]) q5cnt = q5cnt + 1;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic pulse(input bit do_hs, input bit do_fs);
    @(negedge cp);
    if (do_hs) hs_n = 1'b0;
    if (do_fs) fs_n = 1'b0;
    repeat (2) @(negedge cp);
    hs_n = 1'b1;
    fs_n = 1'b1;
    repeat (2) @(negedge cp);
    #1;
  endtask

  task automatic hs_pulses(input int n);
    for (int i = 0; i < n; i++) pulse(1'b1, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    cmp  = {9'd24, 9'd5};
    cmp5 = 5'd7;
    repeat (3) @(negedge cp);
    #1;
    chk("rst_row", row, 0);
    chk("rst_q", q, 0);
    chk("rst_active", active, 0);
    chk("rst_ovf", ovf, 0);
    mr_n = 1'b1;
    repeat (5) @(negedge cp);

    // hs before any fs is ignored
    hs_pulses(3);
    chk("idle_row", row, 0);
    chk("idle_active", active, 0);
    chk("idle_q0cnt", qcnt0, 0);

    // basic field: q0 at row 5, q1 at row 24
    pulse(1'b0, 1'b1);
    chk("fs_active", active, 1);
    chk("fs_row", row, 0);
    hs_pulses(24);
    chk("f1_q0cnt", qcnt0, 1);
    chk("f1_q0row", qrow0, 5);
    chk("f1_q1cnt", qcnt1, 1);
    chk("f1_q1row", qrow1, 24);
    chk("f1_row", row, 24);
    chk("f1_active", active, 1);
    chk("w5_q5cnt", q5cnt, 1);

    // saturation on the 5-bit instance
    hs_pulses(16);
    chk("sat_row5", row5, 31);
    chk("sat_ovf5", ovf5, 1);
    chk("sat_active5", active5, 0);
    chk("sat_row9", row, 40);
    chk("sat_ovf9", ovf, 0);
    chk("sat_q0cnt", qcnt0, 1);
    pulse(1'b0, 1'b1);
    chk("resat_row5", row5, 0);
    chk("resat_ovf5", ovf5, 0);
    chk("resat_active5", active5, 1);

    // cmp change mid-field takes effect next field
    cmp = {9'd24, 9'd10};
    pulse(1'b0, 1'b1);
    c0 = qcnt0;
    hs_pulses(5);
    cmp = {9'd24, 9'd3};
    hs_pulses(7);
    chk("chg_q0cnt", qcnt0 - c0, 1);
    chk("chg_q0row", qrow0, 10);
    chk("chg_row", row, 12);
    pulse(1'b0, 1'b1);
    c0 = qcnt0;
    hs_pulses(5);
    chk("chg2_q0cnt", qcnt0 - c0, 1);
    chk("chg2_q0row", qrow0, 3);

    // coincident fs/hs counts as fs only; cmp 0 fires on the fs update
    cmp = {9'd24, 9'd0};
    c0 = qcnt0;
    pulse(1'b1, 1'b1);
    chk("both_row", row, 0);
    chk("both_active", active, 1);
    chk("both_q0cnt", qcnt0 - c0, 1);
    chk("both_q0row", qrow0, 0);
    hs_pulses(1);
    chk("both2_row", row, 1);
    chk("both2_q0cnt", qcnt0 - c0, 1);

    // hs latency
    @(negedge cp);
    hs_n = 1'b0;
    for (int k = 1; k <= LAT; k++) begin
      @(posedge cp);
      #1;
      chk("lat_row", row, (k == LAT) ? 32'd2 : 32'd1);
    end
    repeat (2) @(negedge cp);
    hs_n = 1'b1;
    repeat (3) @(negedge cp);
    #1;

    // asynchronous reset mid-field
    hs_pulses(10);
    chk("pre_rst_row", row, 12);
    @(negedge cp);
    #2;
    mr_n = 1'b0;
    #1;
    chk("arst_row", row, 0);
    chk("arst_q", q, 0);
    chk("arst_active", active, 0);
    chk("arst_ovf", ovf, 0);
    chk("arst_row5", row5, 0);
    fs_n = 1'b0;
    repeat (3) @(negedge cp);
    mr_n = 1'b1;
    repeat (6) @(negedge cp);
    #1;
    chk("held_fs_active", active, 0);
    fs_n = 1'b1;
    repeat (4) @(negedge cp);
    hs_pulses(3);
    chk("post_rst_row", row, 0);
    chk("post_rst_active", active, 0);
    pulse(1'b0, 1'b1);
    chk("post_fs_active", active, 1);
    chk("post_fs_row", row, 0);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
